byte_deserializer: RTL

BYTE_DESERIALIZER -- requirements
Module: byte_deserializer

---
 rtl/byte_deserializer.sv | 67 ++++++
 1 files changed

// File: rtl/byte_deserializer.sv
// byte_deserializer: serial-to-parallel word assembler with in_sof resync
// and a single output register under ready/valid backpressure.
module byte_deserializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sync_err
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_k;
    logic [CW-1:0]    w_pos;
    logic [CW-1:0]    w_cnt_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_word;
    logic             r_out_valid;
    logic             r_sync_err;
    logic             w_accept;
    logic             w_done;

    // Only the last bit of a word can stall: it needs a free output register.
    always_comb begin
        in_ready   = rst || !(r_cnt == LAST && r_out_valid && !out_ready);
        w_accept   = in_valid && in_ready && !rst;
        w_k        = in_sof ? '0 : r_cnt;
        w_pos      = MSB_FIRST ? LAST - w_k : w_k;
        w_done     = w_accept && w_k == LAST;
        w_cnt_next = w_done ? '0 : w_k + 1'b1;
        w_word     = r_shift;
        w_word[w_pos] = in_bit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= w_cnt_next;
                r_shift <= w_word;
            end
            if (w_done)
                r_out <= w_word;
            r_out_valid <= w_done || (r_out_valid && !out_ready);
            r_sync_err  <= w_accept && in_sof && r_cnt != '0;
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign sync_err  = r_sync_err;
endmodule
